mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 64, address width; DATA_W, default 64, data width; STARVE_LIMIT, default 4, consecutive DM grants allowed while IF waits.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 if_req  input  1  fetch request; held with if_addr until if_done.
REQ-005 if_addr  input  ADDR_W  fetch address.
REQ-006 if_done  output  1  one-cycle fetch completion pulse.
REQ-007 if_rdata  output  32  fetched instruction, mem_rdata[31:0] latched; valid while if_done=1.
REQ-008 dm_req  input  1  data request; held with dm_we/dm_addr/dm_wdata until dm_done.
REQ-009 dm_we  input  1  1=store, 0=load.
REQ-010 dm_addr  input  ADDR_W  data address.
REQ-011 dm_wdata  input  DATA_W  store data.
REQ-012 dm_done  output  1  one-cycle data completion pulse.
REQ-013 dm_rdata  output  DATA_W  load data, latched; valid while dm_done=1.
REQ-014 mem_req, mem_we  output  1 each  request and write enable to the shared single-port memory.
REQ-015 mem_addr  output  ADDR_W, mem_wdata  output  DATA_W  memory address and write data.
REQ-016 mem_ready  input  1, mem_rdata  input  DATA_W  memory completion and read data.
REQ-017 stall_if, stall_mem  output  1 each  pipeline stall to PC/IFID and to EX/MEM.
REQ-018 if_grant_cnt, dm_grant_cnt, conflict_cnt  output  32 each  performance counters (see Configuration).

Function
REQ-019 FSM states SHALL be IDLE, IF_BUSY and DM_BUSY.
REQ-020 In IDLE, a requester whose done output is 1 in the current cycle SHALL be ignored for arbitration.
REQ-021 In IDLE, dm_req alone -> DM_BUSY; if_req alone -> IF_BUSY; both -> DM_BUSY unless starve_cnt >= STARVE_LIMIT, in which case -> IF_BUSY.
REQ-022 starve_cnt (3 bits minimum, saturating) SHALL increment on each DM grant made while if_req=1, and SHALL clear on every IF grant.
REQ-023 From the cycle after a grant, mem_req SHALL be 1 and mem_we/mem_addr/mem_wdata SHALL carry the granted requester's registered values (IF: mem_we=0, mem_wdata=0); these SHALL remain stable until mem_ready is sampled high.
REQ-024 On the edge where mem_ready=1 is sampled in a BUSY state: mem_rdata SHALL be latched, the matching done SHALL be 1 for exactly the next cycle, mem_req SHALL drop to 0, and the state SHALL return to IDLE.
REQ-025 Minimum latency from request to done SHALL be 3 cycles (grant, mem_req with mem_ready=1, done); there SHALL be no more than one outstanding memory transaction.
REQ-026 A new grant SHALL be possible in the same cycle that the previous done is asserted (back-to-back service of the other requester).
REQ-027 stall_if SHALL equal if_req & ~if_done, and stall_mem SHALL equal dm_req & ~dm_done (combinational).
REQ-028 Deassertion of a request while that requester is granted SHALL NOT abort the transaction; its done SHALL still pulse.

Reset
REQ-029 reset=1 SHALL force IDLE, clear starve_cnt, set mem_req/mem_we/if_done/dm_done to 0, clear mem_addr/mem_wdata/if_rdata/dm_rdata, and clear all counters, all at the next edge.
REQ-030 A reset asserted mid-transaction SHALL abandon that transaction; no done pulse SHALL follow it.

Configuration
REQ-031 With ARB_PERF_CNT_EN defined: if_grant_cnt and dm_grant_cnt SHALL increment per grant, and conflict_cnt SHALL increment per IDLE cycle with both requests eligible; all three wrap modulo 2^32.
REQ-032 Without ARB_PERF_CNT_EN: the counter ports SHALL exist and SHALL be driven constant 0, with no counter flops.

Verification
REQ-033 if_req=1, if_addr=0x10, mem_ready=1 always, mem_rdata=0x00A00093 -> mem_req high at cycle 1; if_done and if_rdata=0x00A00093 at cycle 2; stall_if=1 at cycles 0-1.
REQ-034 if_req and dm_req (dm_we=1, dm_addr=0x20, dm_wdata=0x5) rise together -> DM is served first (mem_we=1, mem_addr=0x20), and IF is granted in the dm_done cycle.
REQ-035 With if_req held and dm_req re-raised immediately after every dm_done, STARVE_LIMIT=4 -> 4 DM grants, then 1 IF grant, then starve_cnt=0.
REQ-036 mem_ready held low for 5 cycles during a DM load -> mem_req and mem_addr stay stable for 5 cycles and stall_mem=1 throughout; dm_done is 1 for a single cycle.
REQ-037 reset pulsed in the second cycle of IF_BUSY -> mem_req=0 on the next cycle, no if_done, and all counters read 0.
REQ-038 Build with ARB_PERF_CNT_EN, 3 IF and 2 DM transactions including 1 conflict -> if_grant_cnt=3, dm_grant_cnt=2, conflict_cnt=1; build without it -> all three counters read 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and shared-memory signals around mem_port_arbiter.
// The master modport is the arbiter's view. The slave modport is the view of the pipeline and memory.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   // Handshake: a requester raises *_req with its address/data and holds them
   // stable until its *_done pulses for one cycle. The arbiter holds mem_req and
   // mem_* stable until mem_ready is sampled high, which completes the access.
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_done;
   logic [31:0]       if_rdata;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_done;
   logic [DATA_W-1:0] dm_rdata;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;
   logic              stall_if;
   logic              stall_mem;

   modport master (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ready, mem_rdata,
      output if_done, if_rdata, dm_done, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata,
      output stall_if, stall_mem
   );

   modport slave (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ready, mem_rdata,
      input  if_done, if_rdata, dm_done, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata,
      input  stall_if, stall_mem
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data access onto one single-port memory, with DM priority and an IF anti-starvation limit.
// Define ARB_PERF_CNT_EN to build the grant/conflict performance counters; otherwise they read 0.
module mem_port_arbiter #(
   parameter int ADDR_W       = 64,
   parameter int DATA_W       = 64,
   parameter int STARVE_LIMIT = 4
) (
   input  logic               clk,
   input  logic               reset,
   mem_port_arbiter_if.master bus,
   output logic [31:0]        if_grant_cnt,
   output logic [31:0]        dm_grant_cnt,
   output logic [31:0]        conflict_cnt,
   output logic [1:0]         dbg_state,
   output logic [7:0]         dbg_starve_cnt
);
   localparam int SW = (STARVE_LIMIT < 7) ? 3 : $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, IF_BUSY = 2'd1, DM_BUSY = 2'd2} state_e;

   state_e            state_q, state_d;
   logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              if_done_q, if_done_d;
   logic [31:0]       if_rdata_q, if_rdata_d;
   logic              dm_done_q, dm_done_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              if_elig, dm_elig;
   logic              if_grant, dm_grant;

   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      if_done_d    = 1'b0;
      if_rdata_d   = if_rdata_q;
      dm_done_d    = 1'b0;
      dm_rdata_d   = dm_rdata_q;
      if_grant     = 1'b0;
      dm_grant     = 1'b0;
      // A requester finishing this cycle is still holding its req; do not re-serve it.
      if_elig      = bus.if_req & ~if_done_q;
      dm_elig      = bus.dm_req & ~dm_done_q;

      case (state_q)
         IDLE: begin
            if (dm_elig && (!if_elig || int'(starve_cnt_q) < STARVE_LIMIT)) dm_grant = 1'b1;
            else if (if_elig) if_grant = 1'b1;
         end
         IF_BUSY: begin
            if (bus.mem_ready) begin
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               mem_we_d   = 1'b0;
               if_done_d  = 1'b1;
               if_rdata_d = bus.mem_rdata[31:0];
            end
         end
         DM_BUSY: begin
            if (bus.mem_ready) begin
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               mem_we_d   = 1'b0;
               dm_done_d  = 1'b1;
               dm_rdata_d = bus.mem_rdata;
            end
         end
         default: state_d = IDLE;
      endcase

      if (dm_grant) begin
         state_d     = DM_BUSY;
         mem_req_d   = 1'b1;
         mem_we_d    = bus.dm_we;
         mem_addr_d  = bus.dm_addr;
         mem_wdata_d = bus.dm_wdata;
         if (bus.if_req && starve_cnt_q != '1) starve_cnt_d = starve_cnt_q + SW'(1);
      end
      if (if_grant) begin
         state_d      = IF_BUSY;
         mem_req_d    = 1'b1;
         mem_we_d     = 1'b0;
         mem_addr_d   = bus.if_addr;
         mem_wdata_d  = '0;
         starve_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         starve_cnt_q <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         if_done_q    <= 1'b0;
         if_rdata_q   <= '0;
         dm_done_q    <= 1'b0;
         dm_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         if_done_q    <= if_done_d;
         if_rdata_q   <= if_rdata_d;
         dm_done_q    <= dm_done_d;
         dm_rdata_q   <= dm_rdata_d;
      end
   end

`ifdef ARB_PERF_CNT_EN
   logic [31:0] if_grant_cnt_q, if_grant_cnt_d;
   logic [31:0] dm_grant_cnt_q, dm_grant_cnt_d;
   logic [31:0] conflict_cnt_q, conflict_cnt_d;

   always_comb begin
      if_grant_cnt_d = if_grant_cnt_q;
      dm_grant_cnt_d = dm_grant_cnt_q;
      conflict_cnt_d = conflict_cnt_q;
      if (if_grant) if_grant_cnt_d = if_grant_cnt_q + 32'd1;
      if (dm_grant) dm_grant_cnt_d = dm_grant_cnt_q + 32'd1;
      if (state_q == IDLE && if_elig && dm_elig) conflict_cnt_d = conflict_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         if_grant_cnt_q <= '0;
         dm_grant_cnt_q <= '0;
         conflict_cnt_q <= '0;
      end else begin
         if_grant_cnt_q <= if_grant_cnt_d;
         dm_grant_cnt_q <= dm_grant_cnt_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign if_grant_cnt = if_grant_cnt_q;
   assign dm_grant_cnt = dm_grant_cnt_q;
   assign conflict_cnt = conflict_cnt_q;
`else
   assign if_grant_cnt = '0;
   assign dm_grant_cnt = '0;
   assign conflict_cnt = '0;
`endif

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_done   = if_done_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_done   = dm_done_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.stall_if  = bus.if_req & ~if_done_q;
   assign bus.stall_mem = bus.dm_req & ~dm_done_q;
   assign dbg_state      = state_q;
   assign dbg_starve_cnt = 8'(starve_cnt_q);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: reset, fetch, DM-first conflict, memory wait,
// starvation limit, mid-transaction reset and the performance counters.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] if_grant_cnt, dm_grant_cnt, conflict_cnt;
  logic [1:0]  dbg_state;
  logic [7:0]  dbg_starve_cnt;
  int          vec_cnt = 0;
  int          err_cnt = 0;

  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .if_grant_cnt   (if_grant_cnt),
    .dm_grant_cnt   (dm_grant_cnt),
    .conflict_cnt   (conflict_cnt),
    .dbg_state      (dbg_state),
    .dbg_starve_cnt (dbg_starve_cnt)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected summary");
    $fatal(1);
  end

  // driver tasks: inputs change 1ns after the rising edge, outputs are read on the falling edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    step();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    sample();
    vec_cnt++; if (bus.mem_req !== 1'b0) begin err_cnt++; $display("FAIL rst_mem_req: got %b expected 0", bus.mem_req); end
    vec_cnt++; if (bus.mem_we !== 1'b0) begin err_cnt++; $display("FAIL rst_mem_we: got %b expected 0", bus.mem_we); end
    vec_cnt++; if (bus.if_done !== 1'b0 || bus.dm_done !== 1'b0) begin err_cnt++; $display("FAIL rst_done: got if=%b dm=%b expected 0 0", bus.if_done, bus.dm_done); end
    vec_cnt++; if (bus.mem_addr !== 64'h0) begin err_cnt++; $display("FAIL rst_mem_addr: got %h expected 0", bus.mem_addr); end
    vec_cnt++; if (bus.if_rdata !== 32'h0 || bus.dm_rdata !== 64'h0) begin err_cnt++; $display("FAIL rst_rdata: got %h %h expected 0 0", bus.if_rdata, bus.dm_rdata); end
    vec_cnt++; if (dbg_state !== 2'd0) begin err_cnt++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
    vec_cnt++; if ({if_grant_cnt, dm_grant_cnt, conflict_cnt} !== 96'h0) begin err_cnt++; $display("FAIL rst_counters: got %0d %0d %0d expected 0 0 0", if_grant_cnt, dm_grant_cnt, conflict_cnt); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_if_fetch();
    idle_inputs();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 64'h0000_0000_00A0_0093;
    bus.if_req    = 1'b1;
    bus.if_addr   = 64'h10;
    sample();
    vec_cnt++; if (bus.mem_req !== 1'b0 || bus.stall_if !== 1'b1) begin err_cnt++; $display("FAIL fetch_c0: got mem_req=%b stall_if=%b expected 0 1", bus.mem_req, bus.stall_if); end
    step(); sample();
    vec_cnt++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 64'h10 || bus.mem_we !== 1'b0 || bus.mem_wdata !== 64'h0) begin err_cnt++; $display("FAIL fetch_c1_bus: got req=%b addr=%h we=%b wdata=%h expected 1 10 0 0", bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wdata); end
    vec_cnt++; if (bus.stall_if !== 1'b1 || bus.if_done !== 1'b0) begin err_cnt++; $display("FAIL fetch_c1_stall: got stall_if=%b if_done=%b expected 1 0", bus.stall_if, bus.if_done); end
    step(); sample();
    vec_cnt++; if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'h00A00093) begin err_cnt++; $display("FAIL fetch_c2_done: got done=%b rdata=%h expected 1 00a00093", bus.if_done, bus.if_rdata); end
    vec_cnt++; if (bus.stall_if !== 1'b0 || bus.mem_req !== 1'b0) begin err_cnt++; $display("FAIL fetch_c2_idle: got stall_if=%b mem_req=%b expected 0 0", bus.stall_if, bus.mem_req); end
    step();
    bus.if_req = 1'b0;
    sample();
    vec_cnt++; if (bus.if_done !== 1'b0 || dbg_state !== 2'd0) begin err_cnt++; $display("FAIL fetch_c3_pulse: got done=%b state=%0d expected 0 0", bus.if_done, dbg_state); end
  endtask

  task automatic test_conflict();
    idle_inputs();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 64'h1234_5678_9ABC_DEF0;
    bus.if_req    = 1'b1;
    bus.if_addr   = 64'h40;
    bus.dm_req    = 1'b1;
    bus.dm_we     = 1'b1;
    bus.dm_addr   = 64'h20;
    bus.dm_wdata  = 64'h5;
    step(); sample();
    vec_cnt++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 64'h20 || bus.mem_wdata !== 64'h5) begin err_cnt++; $display("FAIL conflict_dm_first: got req=%b we=%b addr=%h wdata=%h expected 1 1 20 5", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    vec_cnt++; if (bus.stall_if !== 1'b1 || bus.stall_mem !== 1'b1) begin err_cnt++; $display("FAIL conflict_stalls: got stall_if=%b stall_mem=%b expected 1 1", bus.stall_if, bus.stall_mem); end
    step(); sample();
    vec_cnt++; if (bus.dm_done !== 1'b1 || bus.dm_rdata !== 64'h1234_5678_9ABC_DEF0 || bus.stall_mem !== 1'b0) begin err_cnt++; $display("FAIL conflict_dm_done: got done=%b rdata=%h stall_mem=%b expected 1 123456789abcdef0 0", bus.dm_done, bus.dm_rdata, bus.stall_mem); end
    step();
    bus.dm_req = 1'b0;
    sample();
    vec_cnt++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 64'h40 || bus.mem_we !== 1'b0 || bus.mem_wdata !== 64'h0 || dbg_state !== 2'd1) begin err_cnt++; $display("FAIL conflict_if_b2b: got req=%b addr=%h we=%b wdata=%h state=%0d expected 1 40 0 0 1", bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wdata, dbg_state); end
    vec_cnt++; if (bus.dm_done !== 1'b0) begin err_cnt++; $display("FAIL conflict_dm_pulse: got %b expected 0", bus.dm_done); end
    step(); sample();
    vec_cnt++; if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'h9ABC_DEF0) begin err_cnt++; $display("FAIL conflict_if_done: got done=%b rdata=%h expected 1 9abcdef0", bus.if_done, bus.if_rdata); end
    step();
    bus.if_req = 1'b0;
  endtask

  task automatic test_mem_wait();
    idle_inputs();
    bus.mem_rdata = 64'hCAFE_0000_BEEF_0001;
    bus.dm_req    = 1'b1;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = 64'h88;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 6) bus.mem_ready = 1'b1;
      sample();
      vec_cnt++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 64'h88 || bus.mem_we !== 1'b0 || bus.stall_mem !== 1'b1 || bus.dm_done !== 1'b0) begin err_cnt++; $display("FAIL wait_hold c%0d: got req=%b addr=%h we=%b stall=%b done=%b expected 1 88 0 1 0", c, bus.mem_req, bus.mem_addr, bus.mem_we, bus.stall_mem, bus.dm_done); end
    end
    step(); sample();
    vec_cnt++; if (bus.dm_done !== 1'b1 || bus.dm_rdata !== 64'hCAFE_0000_BEEF_0001 || bus.mem_req !== 1'b0) begin err_cnt++; $display("FAIL wait_done: got done=%b rdata=%h req=%b expected 1 cafe0000beef0001 0", bus.dm_done, bus.dm_rdata, bus.mem_req); end
    step();
    bus.dm_req = 1'b0;
    sample();
    vec_cnt++; if (bus.dm_done !== 1'b0) begin err_cnt++; $display("FAIL wait_pulse: got %b expected 0", bus.dm_done); end
  endtask

  task automatic test_counters();
    logic [31:0] exp_if, exp_dm, exp_cf;
`ifdef ARB_PERF_CNT_EN
    exp_if = 32'd3; exp_dm = 32'd2; exp_cf = 32'd1;
`else
    exp_if = 32'd0; exp_dm = 32'd0; exp_cf = 32'd0;
`endif
    sample();
    vec_cnt++; if (if_grant_cnt !== exp_if) begin err_cnt++; $display("FAIL cnt_if: got %0d expected %0d", if_grant_cnt, exp_if); end
    vec_cnt++; if (dm_grant_cnt !== exp_dm) begin err_cnt++; $display("FAIL cnt_dm: got %0d expected %0d", dm_grant_cnt, exp_dm); end
    vec_cnt++; if (conflict_cnt !== exp_cf) begin err_cnt++; $display("FAIL cnt_conflict: got %0d expected %0d", conflict_cnt, exp_cf); end
  endtask

  task automatic test_starvation();
    idle_inputs();
    bus.mem_ready = 1'b1;
    bus.if_addr   = 64'h200;
    bus.dm_we     = 1'b0;
    // IF idles only in each dm_done cycle, so DM keeps winning until the limit forces IF in.
    for (int k = 0; k < 4; k++) begin
      step();
      bus.if_req  = 1'b1;
      bus.dm_req  = 1'b1;
      bus.dm_addr = 64'h100 + 64'(k);
      step(); sample();
      vec_cnt++; if (bus.mem_addr !== 64'h100 + 64'(k) || dbg_state !== 2'd2 || dbg_starve_cnt !== 8'(k + 1)) begin err_cnt++; $display("FAIL starve_dm r%0d: got addr=%h state=%0d starve=%0d expected %h 2 %0d", k, bus.mem_addr, dbg_state, dbg_starve_cnt, 64'h100 + 64'(k), k + 1); end
      step();
      bus.if_req = 1'b0;
      bus.dm_req = 1'b0;
      sample();
      vec_cnt++; if (bus.dm_done !== 1'b1) begin err_cnt++; $display("FAIL starve_done r%0d: got %b expected 1", k, bus.dm_done); end
    end
    step();
    bus.if_req  = 1'b1;
    bus.dm_req  = 1'b1;
    bus.dm_addr = 64'h180;
    step(); sample();
    vec_cnt++; if (bus.mem_addr !== 64'h200 || bus.mem_we !== 1'b0 || dbg_state !== 2'd1) begin err_cnt++; $display("FAIL starve_if_grant: got addr=%h we=%b state=%0d expected 200 0 1", bus.mem_addr, bus.mem_we, dbg_state); end
    vec_cnt++; if (dbg_starve_cnt !== 8'd0) begin err_cnt++; $display("FAIL starve_clear: got %0d expected 0", dbg_starve_cnt); end
    step();
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    sample();
    vec_cnt++; if (bus.if_done !== 1'b1) begin err_cnt++; $display("FAIL starve_if_done: got %b expected 1", bus.if_done); end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h300;
    step();
    step();
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    sample();
    vec_cnt++; if (bus.mem_req !== 1'b1 || dbg_state !== 2'd1) begin err_cnt++; $display("FAIL rmid_busy: got req=%b state=%0d expected 1 1", bus.mem_req, dbg_state); end
    step();
    reset         = 1'b0;
    bus.if_req    = 1'b0;
    bus.mem_ready = 1'b0;
    sample();
    vec_cnt++; if (bus.mem_req !== 1'b0 || bus.if_done !== 1'b0 || dbg_state !== 2'd0) begin err_cnt++; $display("FAIL rmid_abandon: got req=%b done=%b state=%0d expected 0 0 0", bus.mem_req, bus.if_done, dbg_state); end
    vec_cnt++; if ({if_grant_cnt, dm_grant_cnt, conflict_cnt} !== 96'h0) begin err_cnt++; $display("FAIL rmid_counters: got %0d %0d %0d expected 0 0 0", if_grant_cnt, dm_grant_cnt, conflict_cnt); end
    step(); sample();
    vec_cnt++; if (bus.if_done !== 1'b0 || bus.mem_req !== 1'b0) begin err_cnt++; $display("FAIL rmid_no_done: got done=%b req=%b expected 0 0", bus.if_done, bus.mem_req); end
  endtask

  initial begin
    test_reset();
    test_if_fetch();
    test_conflict();
    test_mem_wait();
    test_if_fetch();
    test_counters();
    test_starvation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
